// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requesters, reservation input and register file write port bundle
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREG = 16
);
  logic alu_req;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic alu_gnt;
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic mem_gnt;
  logic rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic [NREG-1:0] busy_vec;
  logic rf_write_enable;
  logic [ADDR_W-1:0] rf_write_register;
  logic [DATA_W-1:0] rf_write_data;
  logic sb_err;
  modport slave (
    input alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data, rsv_valid, rsv_addr,
    output alu_gnt, mem_gnt, busy_vec, rf_write_enable, rf_write_register, rf_write_data, sb_err
  );
  modport master (
    output alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data, rsv_valid, rsv_addr,
    input alu_gnt, mem_gnt, busy_vec, rf_write_enable, rf_write_register, rf_write_data, sb_err
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register file write port between ALU and load path, with busy scoreboard
// Optional macro SB_CHECK_EN builds the sticky sb_err check for writes to unreserved registers.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NREG = 16
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  typedef enum logic {GNT_ALU, GNT_MEM} grant_e;
  grant_e last_q, last_d;
  logic alu_gnt, mem_gnt, xfer;
  logic [ADDR_W-1:0] xaddr, waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d;
  logic [NREG-1:0] busy_q, busy_d;
  always_comb begin
    alu_gnt = bus.alu_req & (~bus.mem_req | (last_q == GNT_MEM));
    mem_gnt = bus.mem_req & (~bus.alu_req | (last_q == GNT_ALU));
    xfer = alu_gnt | mem_gnt;
    xaddr = alu_gnt ? bus.alu_addr : bus.mem_addr;
    last_d = alu_gnt ? GNT_ALU : mem_gnt ? GNT_MEM : last_q;
    we_d = xfer;
    waddr_d = xfer ? xaddr : waddr_q;
    wdata_d = alu_gnt ? bus.alu_data : mem_gnt ? bus.mem_data : wdata_q;
    busy_d = busy_q;
    if (xfer) busy_d[xaddr] = 1'b0;
    // a fresh reservation supersedes the retiring write to the same register
    if (bus.rsv_valid) busy_d[bus.rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_q <= GNT_MEM;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q <= '0;
    end else begin
      last_q <= last_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q <= busy_d;
    end
`ifdef SB_CHECK_EN
  logic sb_err_q, sb_err_d;
  always_comb sb_err_d = sb_err_q | (xfer & ~busy_q[xaddr]);
  always_ff @(posedge clk or posedge rst)
    if (rst) sb_err_q <= 1'b0;
    else sb_err_q <= sb_err_d;
  assign bus.sb_err = sb_err_q;
`else
  assign bus.sb_err = 1'b0;
`endif
  assign bus.alu_gnt = alu_gnt;
  assign bus.mem_gnt = mem_gnt;
  assign bus.busy_vec = busy_q;
  assign bus.rf_write_enable = we_q;
  assign bus.rf_write_register = waddr_q;
  assign bus.rf_write_data = wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios with hand-computed expectations for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
`ifdef SB_CHECK_EN
  localparam logic SB_ON = 1'b1;
`else
  localparam logic SB_ON = 1'b0;
`endif
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(4), .NREG(16)) bus ();
  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(4), .NREG(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_req = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.rsv_valid = 1'b0; bus.rsv_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    checks++; if (bus.rf_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.rf_write_enable); end
    checks++; if (bus.rf_write_register !== 4'd0) begin failures++; $display("FAIL reset_reg got=%0d exp=0", bus.rf_write_register); end
    checks++; if (bus.rf_write_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.rf_write_data); end
    checks++; if (bus.busy_vec !== 16'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", bus.busy_vec); end
    checks++; if (bus.sb_err !== 1'b0) begin failures++; $display("FAIL reset_sb_err got=%b exp=0", bus.sb_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_alu();
    do_reset();
    bus.alu_req = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 32'h0000_00AA;
    #1;
    checks++; if (bus.alu_gnt !== 1'b1) begin failures++; $display("FAIL single_alu_gnt got=%b exp=1", bus.alu_gnt); end
    checks++; if (bus.mem_gnt !== 1'b0) begin failures++; $display("FAIL single_mem_gnt got=%b exp=0", bus.mem_gnt); end
    tick();
    bus.alu_req = 1'b0;
    checks++; if (bus.rf_write_enable !== 1'b1) begin failures++; $display("FAIL single_we got=%b exp=1", bus.rf_write_enable); end
    checks++; if (bus.rf_write_register !== 4'd3) begin failures++; $display("FAIL single_reg got=%0d exp=3", bus.rf_write_register); end
    checks++; if (bus.rf_write_data !== 32'hAA) begin failures++; $display("FAIL single_data got=%h exp=000000aa", bus.rf_write_data); end
    tick();
    checks++; if (bus.rf_write_enable !== 1'b0) begin failures++; $display("FAIL idle_we got=%b exp=0", bus.rf_write_enable); end
    checks++; if (bus.rf_write_register !== 4'd3) begin failures++; $display("FAIL idle_reg_hold got=%0d exp=3", bus.rf_write_register); end
    checks++; if (bus.rf_write_data !== 32'hAA) begin failures++; $display("FAIL idle_data_hold got=%h exp=000000aa", bus.rf_write_data); end
  endtask

  task automatic test_alternate();
    logic exp_alu;
    logic [3:0] exp_reg;
    logic [31:0] exp_data;
    do_reset();
    bus.alu_req = 1'b1; bus.alu_addr = 4'd1; bus.alu_data = 32'h1111_1111;
    bus.mem_req = 1'b1; bus.mem_addr = 4'd2; bus.mem_data = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      exp_reg = exp_alu ? 4'd1 : 4'd2;
      exp_data = exp_alu ? 32'h1111_1111 : 32'h2222_2222;
      #1;
      checks++; if (bus.alu_gnt !== exp_alu) begin failures++; $display("FAIL alt_alu_gnt[%0d] got=%b exp=%b", i, bus.alu_gnt, exp_alu); end
      checks++; if (bus.mem_gnt !== !exp_alu) begin failures++; $display("FAIL alt_mem_gnt[%0d] got=%b exp=%b", i, bus.mem_gnt, !exp_alu); end
      tick();
      checks++; if (bus.rf_write_register !== exp_reg) begin failures++; $display("FAIL alt_reg[%0d] got=%0d exp=%0d", i, bus.rf_write_register, exp_reg); end
      checks++; if (bus.rf_write_data !== exp_data) begin failures++; $display("FAIL alt_data[%0d] got=%h exp=%h", i, bus.rf_write_data, exp_data); end
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd5;
    tick();
    bus.rsv_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.busy_vec !== 16'h0020) begin failures++; $display("FAIL sb_busy_hold[%0d] got=%h exp=0020", i, bus.busy_vec); end
      if (i < 2) tick();
    end
    bus.mem_req = 1'b1; bus.mem_addr = 4'd5; bus.mem_data = 32'h0000_0055;
    #1;
    checks++; if (bus.mem_gnt !== 1'b1) begin failures++; $display("FAIL sb_mem_gnt got=%b exp=1", bus.mem_gnt); end
    tick();
    bus.mem_req = 1'b0;
    checks++; if (bus.busy_vec !== 16'h0000) begin failures++; $display("FAIL sb_busy_clear got=%h exp=0000", bus.busy_vec); end
    checks++; if (bus.rf_write_register !== 4'd5) begin failures++; $display("FAIL sb_reg got=%0d exp=5", bus.rf_write_register); end
    checks++; if (bus.rf_write_data !== 32'h55) begin failures++; $display("FAIL sb_data got=%h exp=00000055", bus.rf_write_data); end
  endtask

  task automatic test_same_edge();
    do_reset();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd7;
    bus.alu_req = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 32'h7777_0000;
    tick();
    checks++; if (bus.busy_vec !== 16'h0080) begin failures++; $display("FAIL same_set_wins got=%h exp=0080", bus.busy_vec); end
    checks++; if (bus.rf_write_register !== 4'd7) begin failures++; $display("FAIL same_reg got=%0d exp=7", bus.rf_write_register); end
    bus.rsv_addr = 4'd4;
    tick();
    idle_inputs();
    checks++; if (bus.busy_vec !== 16'h0010) begin failures++; $display("FAIL diff_set_clear got=%h exp=0010", bus.busy_vec); end
  endtask

  task automatic test_sb_err();
    do_reset();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd9;
    tick();
    bus.rsv_valid = 1'b0;
    bus.alu_req = 1'b1; bus.alu_addr = 4'd9; bus.alu_data = 32'h9;
    tick();
    bus.alu_req = 1'b0;
    checks++; if (bus.sb_err !== 1'b0) begin failures++; $display("FAIL sb_err_reserved got=%b exp=0", bus.sb_err); end
    bus.alu_req = 1'b1;
    tick();
    bus.alu_req = 1'b0;
    checks++; if (bus.sb_err !== SB_ON) begin failures++; $display("FAIL sb_err_set got=%b exp=%b", bus.sb_err, SB_ON); end
    tick(); tick();
    checks++; if (bus.sb_err !== SB_ON) begin failures++; $display("FAIL sb_err_sticky got=%b exp=%b", bus.sb_err, SB_ON); end
    rst = 1'b1;
    #1;
    checks++; if (bus.sb_err !== 1'b0) begin failures++; $display("FAIL sb_err_rst got=%b exp=0", bus.sb_err); end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 4; i < 7; i++) begin
      bus.rsv_valid = 1'b1; bus.rsv_addr = 4'(i);
      tick();
    end
    bus.rsv_addr = 4'd7;
    bus.alu_req = 1'b1; bus.alu_addr = 4'd2; bus.alu_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++; if (bus.busy_vec !== 16'h00F0) begin failures++; $display("FAIL pre_rst_busy got=%h exp=00f0", bus.busy_vec); end
    checks++; if (bus.rf_write_enable !== 1'b1) begin failures++; $display("FAIL pre_rst_we got=%b exp=1", bus.rf_write_enable); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.rf_write_enable !== 1'b0) begin failures++; $display("FAIL async_we got=%b exp=0", bus.rf_write_enable); end
    checks++; if (bus.rf_write_register !== 4'd0) begin failures++; $display("FAIL async_reg got=%0d exp=0", bus.rf_write_register); end
    checks++; if (bus.rf_write_data !== 32'd0) begin failures++; $display("FAIL async_data got=%h exp=0", bus.rf_write_data); end
    checks++; if (bus.busy_vec !== 16'd0) begin failures++; $display("FAIL async_busy got=%h exp=0", bus.busy_vec); end
    checks++; if (bus.sb_err !== 1'b0) begin failures++; $display("FAIL async_sb_err got=%b exp=0", bus.sb_err); end
    #1;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_alternate();
    test_scoreboard();
    test_same_edge();
    test_sb_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 16x32 register file between two writeback requesters: the ALU and the memory/load path.
- Keeps a per-register busy scoreboard so the issue logic can stall on pending destinations.
- Sits between the execute/memory stages and the register file write port.
- Drives the register file's write_enable, write_register and write_data inputs directly from registered outputs.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 4, register address width
NREG, 16, number of registers (2**ADDR_W)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
alu_req  input  1  ALU writeback request
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_gnt  output  1  ALU request accepted this cycle (combinational)
mem_req  input  1  memory writeback request
mem_addr  input  ADDR_W  memory destination register
mem_data  input  DATA_W  load data
mem_gnt  output  1  memory request accepted this cycle (combinational)
rsv_valid  input  1  issue stage reserves a destination register
rsv_addr  input  ADDR_W  register being reserved
busy_vec  output  NREG  bit i high = write to register i pending
rf_write_enable  output  1  to register file write_enable (registered)
rf_write_register  output  ADDR_W  to register file write_register (registered)
rf_write_data  output  DATA_W  to register file write_data (registered)
sb_err  output  1  scoreboard violation flag (see Optional Feature)

Behaviour:
- Reset (async, immediate): rf_write_enable=0, rf_write_register=0, rf_write_data=0, busy_vec=0, sb_err=0, last_grant=MEM (ALU wins first tie).
- Handshake: a requester holds req/addr/data stable until it sees gnt=1 in the same cycle. Transfer occurs on the rising edge where req&gnt=1. After that edge, the requester may drop req or present the next request.
- Arbitration (combinational from req and last_grant):
  - Only one req high: it is granted.
  - Both high: the requester not equal to last_grant is granted.
  - Neither high: no grant.
  - last_grant updates only on a transfer.
  - Worst-case wait is 1 cycle; no starvation.
- Write port: on a transfer edge, rf_write_enable<=1 and addr/data are registered from the granted requester. With no transfer, rf_write_enable<=0 and addr/data hold their previous values. Latency is 1 cycle from grant to write_enable at the register file; the register file commits on the following edge.
- Same address from both requesters in consecutive cycles: writes are issued in grant order, so the later grant's data persists.
- Scoreboard:
  - On rsv_valid, set busy_vec[rsv_addr] at the edge.
  - On a transfer, clear busy_vec[granted addr] at the same edge.
  - Set and clear of the same register on the same edge: set wins, because the new reservation supersedes the old one.
  - Set and clear of different registers both apply.
- Reset mid-operation: a pending grant is lost and all busy bits clear. Upstream must re-issue.

Optional Feature:
- Macro: SB_CHECK_EN.
- Defined: sb_err is set (sticky until rst) on any transfer whose destination busy bit is 0 at that edge, i.e. a write without a reservation.
- Not defined: sb_err is tied to 0 and no check logic is built.

Test Plan:
- Reset, then alu_req=1, alu_addr=3, alu_data=0x0000_00AA -> alu_gnt=1 same cycle; next cycle rf_write_enable=1, rf_write_register=3, rf_write_data=0xAA.
- alu_req and mem_req both held high from reset, with addrs 1/2 -> grants alternate ALU, MEM, ALU, MEM; rf_write_register sequence 1, 2, 1, 2.
- rsv_valid with rsv_addr=5, then 3 cycles later mem transfer to reg 5 -> busy_vec[5]=1 from edge 1 until the transfer edge, then 0.
- Same edge: rsv_valid to reg 7 and ALU transfer to reg 7 -> busy_vec[7] remains 1.
- With SB_CHECK_EN defined: ALU transfer to reg 9 with busy_vec[9]=0 -> sb_err=1 and stays 1 until rst; without the macro, sb_err=0.
- Assert rst asynchronously mid-cycle while rf_write_enable=1 and busy_vec=0x00F0 -> all outputs 0 immediately, without waiting for clk.
